// File: rtl/uart_program_loader.sv
// UART program loader: receives a framed word image over 8N1 serial and writes it into
// instruction/data RAM from address 0, holding busy high while a frame is in progress.
module uart_program_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned MAX_WORDS    = 256,
  parameter int unsigned TIMEOUT_CLKS = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_wren,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [31:0]   MAXW    = MAX_WORDS;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [2:0] L_IDLE  = 3'd0;
  localparam logic [2:0] L_CNT_H = 3'd1;
  localparam logic [2:0] L_CNT_L = 3'd2;
  localparam logic [2:0] L_DAT_H = 3'd3;
  localparam logic [2:0] L_DAT_L = 3'd4;
  localparam logic [2:0] L_CHK   = 3'd5;
  localparam logic [2:0] L_DONE  = 3'd6;
  localparam logic [2:0] L_ERR   = 3'd7;

  logic          s1_q, s2_q;
  logic [1:0]    rs_q, rs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          bv_q, bv_d;
  logic          fe_q, fe_d;
  logic          start_det;

  logic [2:0]    ls_q, ls_d;
  logic [15:0]   n_q, n_d;
  logic [7:0]    cnth_q, cnth_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    chk_q, chk_d;
  logic [15:0]   words_q, words_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          wren_q, wren_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [TW-1:0] gap_q, gap_d;
  logic          gap_st, tmo;
  logic [15:0]   n_full, words_inc;

  assign start_det = (rs_q == R_IDLE) && !s2_q;

  // Receiver: start re-checked at half a bit, then every sample lands mid-bit
  always_comb begin
    rs_d  = rs_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d  = sh_q;
    bv_d  = 1'b0;
    fe_d  = 1'b0;
    case (rs_q)
      R_IDLE: begin
        if (!s2_q) begin
          rs_d  = R_START;
          cnt_d = '0;
          bit_d = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          rs_d  = s2_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) rs_d = R_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          rs_d  = R_IDLE;
          bv_d  = s2_q;
          fe_d  = !s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign busy      = (ls_q != L_IDLE) && (ls_q != L_DONE) && (ls_q != L_ERR);
  assign gap_st    = busy && (ls_q != L_CNT_H);
  assign tmo       = gap_st && (rs_q == R_IDLE) && !start_det && (gap_q == TO_M1);
  assign n_full    = {cnth_q, sh_q};
  assign words_inc = words_q + 16'd1;

  always_comb begin
    ls_d    = ls_q;
    n_d     = n_q;
    cnth_d  = cnth_q;
    hi_d    = hi_q;
    chk_d   = chk_q;
    words_d = words_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    gap_d   = gap_q;

    if (start_det || !gap_st) gap_d = '0;
    else if (rs_q == R_IDLE)  gap_d = gap_q + 1'b1;

    if (!busy) begin
      if (start_det) begin
        ls_d    = L_CNT_H;
        done_d  = 1'b0;
        err_d   = 1'b0;
        words_d = '0;
        chk_d   = '0;
        addr_d  = '0;
      end
    end else if (fe_q || tmo) begin
      ls_d  = L_ERR;
      err_d = 1'b1;
    end else if (bv_q) begin
      // The checksum byte is compared against the running value, never folded in
      if (ls_q != L_CHK) chk_d = chk_q ^ sh_q;
      case (ls_q)
        L_CNT_H: begin
          cnth_d = sh_q;
          ls_d   = L_CNT_L;
        end
        L_CNT_L: begin
          n_d = n_full;
          if ({16'd0, n_full} > MAXW) begin
            ls_d  = L_ERR;
            err_d = 1'b1;
          end else if (n_full == 16'd0) begin
            ls_d = L_CHK;
          end else begin
            ls_d = L_DAT_H;
          end
        end
        L_DAT_H: begin
          hi_d = sh_q;
          ls_d = L_DAT_L;
        end
        L_DAT_L: begin
          wren_d  = 1'b1;
          addr_d  = words_q;
          data_d  = {hi_q, sh_q};
          words_d = words_inc;
          ls_d    = (words_inc == n_q) ? L_CHK : L_DAT_H;
        end
        default: begin
          if (sh_q == chk_q) begin
            ls_d   = L_DONE;
            done_d = 1'b1;
          end else begin
            ls_d  = L_ERR;
            err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      rs_q    <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
      ls_q    <= L_IDLE;
      n_q     <= '0;
      cnth_q  <= '0;
      hi_q    <= '0;
      chk_q   <= '0;
      words_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      gap_q   <= '0;
    end else begin
      s1_q    <= rx;
      s2_q    <= s1_q;
      rs_q    <= rs_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
      ls_q    <= ls_d;
      n_q     <= n_d;
      cnth_q  <= cnth_d;
      hi_q    <= hi_d;
      chk_q   <= chk_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
    end
  end

  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign mem_wren = wren_q;
  assign done     = done_q;
  assign err      = err_q;
  assign words    = words_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: serial frames in, RAM writes checked against a queue.
module tb_uart_program_loader;

  localparam int unsigned CPB = 4;
  localparam int unsigned GAP = 2;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words;

  int checks;
  int errors;
  logic [31:0] exp_q [$];

  uart_program_loader #(
    .CLKS_PER_BIT(4),
    .MAX_WORDS(256),
    .TIMEOUT_CLKS(200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_wren(mem_wren),
    .busy(busy),
    .done(done),
    .err(err),
    .words(words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Write monitor: every wren must match the oldest expected {addr,data}
  always @(negedge clk) begin
    if (rst && mem_wren) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e)
          begin
            errors++;
            $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                     mem_addr, mem_data, e[31:16], e[15:0]);
          end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(done || err) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!(done || err)) begin
      errors++;
      $display("FAIL %s_end: done/err never asserted within 300 cycles", name);
    end
  endtask

  task automatic check_status(input string name, input logic e_done, input logic e_err,
                              input logic e_busy, input logic [15:0] e_words);
    checks++;
    if ({done, err, busy, words} !== {e_done, e_err, e_busy, e_words}) begin
      errors++;
      $display("FAIL %s: got done=%b err=%b busy=%b words=%0d, expected done=%b err=%b busy=%b words=%0d",
               name, done, err, busy, words, e_done, e_err, e_busy, e_words);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d writes still outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({mem_addr, mem_data, mem_wren, busy, done, err, words} !== 53'd0) begin
      errors++;
      $display("FAIL reset: got addr=%h data=%h wren=%b busy=%b done=%b err=%b words=%h, expected all 0",
               mem_addr, mem_data, mem_wren, busy, done, err, words);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_load_ok();
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0001, 16'hABCD});
    send_byte(8'h00, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL load_ok_busy: got busy=%b, expected 1", busy);
    end
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h42, 1'b1);
    wait_end("load_ok");
    check_status("load_ok", 1'b1, 1'b0, 1'b0, 16'd2);
  endtask

  task automatic test_bad_checksum();
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0001, 16'hABCD});
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h43, 1'b1);
    wait_end("bad_chk");
    check_status("bad_chk", 1'b0, 1'b1, 1'b0, 16'd2);
  endtask

  task automatic test_boundaries();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_end("zero_words");
    check_status("zero_words", 1'b1, 1'b0, 1'b0, 16'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    wait_end("too_many");
    check_status("too_many", 1'b0, 1'b1, 1'b0, 16'd0);
  endtask

  task automatic test_framing_glitch();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    wait_end("frame_err_dat");
    check_status("frame_err_dat", 1'b0, 1'b1, 1'b0, 16'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b0);
    wait_end("frame_err_cnt");
    check_status("frame_err_cnt", 1'b0, 1'b1, 1'b0, 16'd0);
    // A one-clock low pulse must not become a byte; the following frame must stay aligned
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_end("glitch");
    check_status("glitch", 1'b1, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_timeout();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    check_status("timeout_pre", 1'b0, 1'b0, 1'b1, 16'd0);
    repeat (250) @(negedge clk);
    check_status("timeout", 1'b0, 1'b1, 1'b0, 16'd0);
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_addr, mem_data, mem_wren, busy, done, err, words} !== 53'd0) begin
      errors++;
      $display("FAIL reset_mid: got addr=%h data=%h wren=%b busy=%b done=%b err=%b words=%h, expected all 0",
               mem_addr, mem_data, mem_wren, busy, done, err, words);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0001, 16'hABCD});
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h42, 1'b1);
    wait_end("after_reset");
    check_status("after_reset", 1'b1, 1'b0, 1'b0, 16'd2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    rx  = 1'b1;
    test_reset();
    test_load_ok();
    test_bad_checksum();
    test_boundaries();
    test_framing_glitch();
    test_timeout();
    test_reset_midframe();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
